tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: DW, default 1, bit width of one time slot.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  slot strobe; the block samples din/sync only on edges where en=1.
REQ-005 sync  input  1  frame-start marker; high together with the slot-0 sample.
REQ-006 din  input  DW  serial TDM data, one slot per enabled edge.
REQ-007 dout  output  4*DW  last complete frame, declared [0:4*DW-1]; slot i occupies bits i*DW..i*DW+DW-1, so slot 0 is the leftmost field (same ordering as W[0] on the 4-to-1 mux).
REQ-008 slot  output  2  index of the slot the next enabled edge will capture.
REQ-009 frame_valid  output  1  one-cycle pulse; dout was updated on the previous edge.
REQ-010 sync_err  output  1  one-cycle pulse; sync arrived mid-frame.

Function
REQ-011 The block SHALL have exactly two states: IDLE (waiting for sync) and RUN (slots 1-3 pending).
REQ-012 In IDLE, on an edge with en=1 and sync=1, the block SHALL store din in shadow slot 0, set slot=1 and enter RUN.
REQ-013 In IDLE, an edge with en=1 and sync=0 SHALL be ignored; slot stays 0.
REQ-014 In RUN, on an edge with en=1 and sync=0, the block SHALL store din in shadow[slot] and increment slot.
REQ-015 In RUN, on the edge that captures slot 3, the block SHALL load dout with shadow slots 0-2 and din as slot 3, in that same edge.
REQ-016 On that same edge the block SHALL set frame_valid=1 for exactly one cycle, wrap slot to 0 and return to IDLE.
REQ-017 Latency: dout and frame_valid SHALL change on the edge that samples slot 3, with no additional pipeline stage.
REQ-018 Back-to-back frames: a sync on the enabled edge right after slot 3 SHALL start a new frame with no gap cycle.
REQ-019 Stall: edges with en=1'b0 SHALL leave the state, slot, shadow and dout unchanged.
REQ-020 Stall: on edges with en=1'b0, frame_valid and sync_err SHALL be 0.
REQ-021 Resync: in RUN, sync=1 with en=1 SHALL pulse sync_err for one cycle and discard the partial frame.
REQ-022 Resync: that same edge SHALL capture din as slot 0 of a new frame and set slot=1.
REQ-023 A discarded partial frame SHALL NOT update dout and SHALL NOT assert frame_valid.
REQ-024 dout SHALL hold its value between frames; only a completed frame or reset changes it.
REQ-025 frame_valid and sync_err SHALL be registered outputs and SHALL never be high together.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, slot=0, shadow=0, dout=0, frame_valid=0 and sync_err=0.
REQ-027 A rst asserted mid-frame SHALL discard the partial frame; the first frame after rst deasserts needs a new sync.
REQ-028 While rst=1, all inputs SHALL be ignored.

Verification (DW=1)
REQ-029 Single frame: en=1; din=1,0,1,1 on consecutive edges with sync on the first -> dout=4'b1011 and frame_valid=1 for one cycle after edge 4.
REQ-030 Back-to-back frames: frame 1000, then frame 0111 immediately after -> dout=1000 then 0111, two frame_valid pulses four cycles apart, sync_err=0.
REQ-031 Stall: frame 1110 with en=0 for 3 cycles between slots 1 and 2 -> dout=1110, slot holds at 2 during the stall, frame_valid fires only after the 4th enabled sample.
REQ-032 Resync: sync, din 1, 1, then sync again with din=0, followed by 1, 0, 1 -> sync_err pulses on the second sync, then dout=0101 and exactly one frame_valid.
REQ-033 Reset mid-frame: after two slots of a frame, pulse rst between clock edges -> all outputs clear at once; the following slots without a sync give no frame_valid; a fresh frame 0101 then gives dout=0101.
REQ-034 No sync: en=1 with sync=0 for 8 cycles from IDLE -> slot stays 0, dout unchanged, no pulses.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects one sync-aligned frame of four DW-bit slots
// and presents it in parallel on dout, with frame-complete and resync pulses.
module tdm_demux4 #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  input  logic [DW-1:0]   din,
  output logic [0:4*DW-1] dout,
  output logic [1:0]      slot,
  output logic            frame_valid,
  output logic            sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [DW-1:0]   shadow_0;
  logic [DW-1:0]   shadow_1;
  logic [DW-1:0]   shadow_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= 2'd0;
      shadow_0    <= '0;
      shadow_1    <= '0;
      shadow_2    <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              shadow_0 <= din;
              slot     <= 2'd1;
              state    <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // Mid-frame sync: drop the partial frame and restart on this sample.
              sync_err <= 1'b1;
              shadow_0 <= din;
              slot     <= 2'd1;
            end else if (slot == 2'd3) begin
              dout        <= {shadow_0, shadow_1, shadow_2, din};
              frame_valid <= 1'b1;
              slot        <= 2'd0;
              state       <= IDLE;
            end else begin
              if (slot == 2'd1) shadow_1 <= din;
              else              shadow_2 <= din;
              slot <= slot + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (DW=1): vector table, directed corner sequences
// and randomized traffic against a queue-based frame model.
module tb_tdm_demux4;
  localparam int DW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            sync;
  logic [DW-1:0]   din;
  logic [0:4*DW-1] dout;
  logic [1:0]      slot;
  logic            frame_valid;
  logic            sync_err;

  int checks = 0;
  int failures = 0;

  // Reference model: samples of the frame in progress, last finished frame, pulses.
  logic [DW-1:0]   mq[$];
  logic [4*DW-1:0] m_dout;
  logic            m_fv;
  logic            m_se;

  typedef struct {
    logic       e;
    logic       s;
    logic       d;
    logic [3:0] x_dout;
    logic [1:0] x_slot;
    logic       x_fv;
    logic       x_se;
  } vec_t;

  vec_t vecs[$];
  int   fv_count;

  tdm_demux4 #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
    .dout(dout), .slot(slot), .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic s, input logic [DW-1:0] d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (e) begin
      if (s) begin
        if (mq.size() > 0) m_se = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() > 0) begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          m_dout = {mq[0], mq[1], mq[2], mq[3]};
          m_fv = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    chk({tag, ".slot"}, 32'(slot), 32'(mq.size()));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_se));
    if (frame_valid && sync_err) chk({tag, ".pulse_overlap"}, 32'(1), 32'(0));
  endtask

  task automatic step(input logic e, input logic s, input logic [DW-1:0] d, input string tag);
    en = e; sync = s; din = d;
    @(posedge clk);
    model_edge(e, s, d);
    #1;
    if (frame_valid) fv_count++;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
    model_reset();
    fv_count = 0;
    #3;
    chk("reset.dout", 32'(dout), 32'h0);
    chk("reset.slot", 32'(slot), 32'h0);
    chk("reset.frame_valid", 32'(frame_valid), 32'h0);
    chk("reset.sync_err", 32'(sync_err), 32'h0);
    #9 rst = 1'b0;

    // Single frame 1011, back-to-back 1000/0111, then eight unsynced samples.
    vecs = '{
      '{1,1,1, 4'b0000, 2'd1, 0, 0}, '{1,0,0, 4'b0000, 2'd2, 0, 0},
      '{1,0,1, 4'b0000, 2'd3, 0, 0}, '{1,0,1, 4'b1011, 2'd0, 1, 0},
      '{0,0,0, 4'b1011, 2'd0, 0, 0},
      '{1,1,1, 4'b1011, 2'd1, 0, 0}, '{1,0,0, 4'b1011, 2'd2, 0, 0},
      '{1,0,0, 4'b1011, 2'd3, 0, 0}, '{1,0,0, 4'b1000, 2'd0, 1, 0},
      '{1,1,0, 4'b1000, 2'd1, 0, 0}, '{1,0,1, 4'b1000, 2'd2, 0, 0},
      '{1,0,1, 4'b1000, 2'd3, 0, 0}, '{1,0,1, 4'b0111, 2'd0, 1, 0},
      '{1,0,1, 4'b0111, 2'd0, 0, 0}, '{1,0,0, 4'b0111, 2'd0, 0, 0},
      '{1,0,1, 4'b0111, 2'd0, 0, 0}, '{1,0,1, 4'b0111, 2'd0, 0, 0},
      '{1,0,0, 4'b0111, 2'd0, 0, 0}, '{1,0,1, 4'b0111, 2'd0, 0, 0},
      '{1,0,1, 4'b0111, 2'd0, 0, 0}, '{1,0,0, 4'b0111, 2'd0, 0, 0}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].e; sync = vecs[i].s; din = vecs[i].d;
      @(posedge clk);
      model_edge(vecs[i].e, vecs[i].s, vecs[i].d);
      #1;
      chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].x_dout));
      chk($sformatf("vec%0d.slot", i), 32'(slot), 32'(vecs[i].x_slot));
      chk($sformatf("vec%0d.frame_valid", i), 32'(frame_valid), 32'(vecs[i].x_fv));
      chk($sformatf("vec%0d.sync_err", i), 32'(sync_err), 32'(vecs[i].x_se));
    end

    // Stall between slots 1 and 2 of frame 1110.
    step(1, 1, 1, "stall.s0");
    step(1, 0, 1, "stall.s1");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, "stall.hold");
      chk("stall.slot_hold", 32'(slot), 32'd2);
    end
    step(1, 0, 1, "stall.s2");
    chk("stall.no_early_fv", 32'(frame_valid), 32'd0);
    step(1, 0, 0, "stall.s3");
    chk("stall.dout", 32'(dout), 32'b1110);
    chk("stall.fv", 32'(frame_valid), 32'd1);

    // Resync mid-frame, then frame 0101 completes.
    fv_count = 0;
    step(1, 1, 1, "resync.a0");
    step(1, 0, 1, "resync.a1");
    step(1, 1, 0, "resync.b0");
    chk("resync.sync_err", 32'(sync_err), 32'd1);
    step(1, 0, 1, "resync.b1");
    step(1, 0, 0, "resync.b2");
    step(1, 0, 1, "resync.b3");
    step(0, 0, 0, "resync.idle");
    chk("resync.dout", 32'(dout), 32'b0101);
    chk("resync.fv_count", 32'(fv_count), 32'd1);

    // Asynchronous reset between edges, mid-frame.
    step(1, 1, 1, "rstmid.s0");
    step(1, 0, 1, "rstmid.s1");
    #2 rst = 1'b1;
    #1;
    chk("rstmid.dout", 32'(dout), 32'h0);
    chk("rstmid.slot", 32'(slot), 32'h0);
    chk("rstmid.frame_valid", 32'(frame_valid), 32'h0);
    chk("rstmid.sync_err", 32'(sync_err), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    fv_count = 0;
    step(1, 0, 1, "rstmid.x2");
    step(1, 0, 1, "rstmid.x3");
    chk("rstmid.no_fv", 32'(fv_count), 32'd0);
    step(1, 1, 0, "rstmid.f0");
    step(1, 0, 1, "rstmid.f1");
    step(1, 0, 0, "rstmid.f2");
    step(1, 0, 1, "rstmid.f3");
    chk("rstmid.dout_new", 32'(dout), 32'b0101);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 6) == 0, DW'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
